// File: rtl/line_fill_mem.sv
// Backing-memory responder for the cache miss path: fixed-latency line fills and
// write-backs, one word per cycle, over a word-addressed store it owns.
module line_fill_mem #(
    parameter int unsigned DEPTH_LOG2      = 10,
    parameter int unsigned LINE_WORDS_LOG2 = 2,
    parameter int unsigned LATENCY         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                wdata_i,
    output logic                       busy_o,
    output logic                       rvalid_o,
    output logic [31:0]                rdata_o,
    output logic                       wready_o,
    output logic [LINE_WORDS_LOG2-1:0] beat_o,
    output logic                       done_o
);

    localparam int unsigned LW         = LINE_WORDS_LOG2;
    localparam int unsigned LINE_WORDS = 1 << LW;
    localparam int unsigned LINE_W     = DEPTH_LOG2 - LW;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [LW-1:0]     beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic              wready_q, wready_d;
    logic              done_q, done_d;

    logic [31:0] mem [DEPTH];

    // Address bits outside the line index are intentionally discarded (aliasing).
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2], addr_i[LW-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            line_q   <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            line_q   <= line_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            wready_q <= wready_d;
            done_q   <= done_d;
        end
    end

    // Next state; output flags are decoded from the next state so they stay registered.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        line_d  = line_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d   = we_i;
                    line_d = addr_i[DEPTH_LOG2-1:LW];
                    beat_d = '0;
                    if (LATENCY == 0) begin
                        state_d = BURST;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            BURST: begin
                if (beat_q == LW'(LINE_WORDS - 1)) begin
                    state_d = DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + LW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d   = (state_d != IDLE);
        rvalid_d = (state_d == BURST) && !we_d;
        wready_d = (state_d == BURST) && we_d;
        done_d   = (state_d == DONE);
    end

    // Store has no reset: completed write beats survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (wready_q) begin
            mem[{line_q, beat_q}] <= wdata_i;
        end
    end

    assign busy_o   = busy_q;
    assign rvalid_o = rvalid_q;
    assign wready_o = wready_q;
    assign done_o   = done_q;
    assign beat_o   = beat_q;
    assign rdata_o  = rvalid_q ? mem[{line_q, beat_q}] : 32'd0;

endmodule
